// File: rtl/uart_loopback_buffer_pkg.sv
// Shared UART definitions: FSM encodings, ASCII control codes and baud divisors.
package uart_loopback_buffer_pkg;

    // Transmit-launch FSM encodings.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;

    // ASCII control codes used for line-ending expansion.
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Baud divisors for the 25 MHz system clock.
    localparam int BAUD_115200 = 217;
    localparam int BAUD_9600   = 2604;

endpackage

// File: rtl/uart_loopback_buffer_fifo.sv
// Synchronous FIFO with registered occupancy flags and a combinational head.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wrEn_i,
    input  logic [DATA_WIDTH-1:0]        wrData_i,
    input  logic                         rdEn_i,
    output logic [DATA_WIDTH-1:0]        rdData_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wrPtr_q;
    logic [PW-1:0]         rdPtr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  doRead;
    logic                  doWrite;

    assign doRead  = rdEn_i & ~empty_q;
    assign doWrite = wrEn_i & (~full_q | doRead);

    // Next occupancy: a simultaneous read and write leave the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({doWrite, doRead})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because the pointers gate access.
    always_ff @(posedge clk_i) begin
        if (doWrite) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (doWrite) wrPtr_q <= wrPtr_q + PW'(1);
            if (doRead)  rdPtr_q <= rdPtr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdData_o = mem_q[rdPtr_q];
    assign count_o  = count_q;
    assign full_o   = full_q;
    assign empty_o  = empty_q;

endmodule

// File: rtl/uart_loopback_buffer.sv
// Byte buffer between UART receiver and transmitter: FIFO, pause, CR->CR LF
// expansion, occupancy/overflow flags and a last-received-byte register.
module uart_loopback_buffer
    import uart_loopback_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] CR_CODE    = DATA_WIDTH'(ASCII_CR),
    parameter logic [DATA_WIDTH-1:0] LF_CODE    = DATA_WIDTH'(ASCII_LF)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [DATA_WIDTH-1:0]      i_rx_byte,
    input  logic                       i_rx_valid,
    input  logic                       i_pause,
    input  logic                       i_crlf_en,
    input  logic                       i_clear_ovf,
    input  logic                       i_tx_active,
    input  logic                       i_tx_done,
    output logic [DATA_WIDTH-1:0]      o_tx_byte,
    output logic                       o_tx_dv,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic [DATA_WIDTH-1:0]      o_last_byte
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  lfPending_q;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] lastByte_q;
    logic [DATA_WIDTH-1:0] txByte_q;
    logic                  txDv_q;
    logic [DATA_WIDTH-1:0] head;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  txReady;
    logic                  launchWindow;
    logic                  launch;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // A launch is only considered when idle or exactly as the current frame ends;
    // S_LAUNCH blocks relaunch until the transmitter reports it went active.
    assign txReady      = ~i_tx_active | i_tx_done;
    assign launchWindow = (state_q == S_IDLE) | ((state_q == S_BUSY) & i_tx_done);
    assign launch       = launchWindow & txReady & ~i_pause & (lfPending_q | ~fifoEmpty);
    assign pop          = launch & ~lfPending_q;
    assign push         = i_rx_valid & (~fifoFull | pop);
    assign drop         = i_rx_valid & ~push;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .wrEn_i   (push),
        .wrData_i (i_rx_byte),
        .rdEn_i   (pop),
        .rdData_o (head),
        .count_o  (o_count),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    // Launch-sequencing FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (launch) state_d = S_LAUNCH;
            S_LAUNCH: if (i_tx_active) state_d = S_BUSY;
            S_BUSY:   if (i_tx_done) state_d = launch ? S_LAUNCH : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM, launch strobe/byte, LF insertion, overflow and last-byte registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            lfPending_q <= 1'b0;
            overflow_q  <= 1'b0;
            lastByte_q  <= '0;
            txByte_q    <= '0;
            txDv_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            txDv_q  <= launch;
            if (launch) begin
                if (lfPending_q) begin
                    txByte_q    <= LF_CODE;
                    lfPending_q <= 1'b0;
                end else begin
                    txByte_q    <= head;
                    lfPending_q <= i_crlf_en & (head == CR_CODE);
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (i_clear_ovf) begin
                overflow_q <= 1'b0;
            end
            if (push) begin
                lastByte_q <= i_rx_byte;
            end
        end
    end

    assign o_tx_byte   = txByte_q;
    assign o_tx_dv     = txDv_q;
    assign o_empty     = fifoEmpty;
    assign o_full      = fifoFull;
    assign o_overflow  = overflow_q;
    assign o_last_byte = lastByte_q;

endmodule

// File: tb/tb_uart_loopback_buffer.sv
// Directed self-checking bench for uart_loopback_buffer with a simple
// transmitter model producing 20-cycle frames.
module tb_uart_loopback_buffer;
    import uart_loopback_buffer_pkg::*;

    localparam int FRAME = 20;

    logic       clk;
    logic       rstN;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       pause;
    logic       crlfEn;
    logic       clearOvf;
    logic       txActive;
    logic       txDone;
    logic [7:0] oTxByte;
    logic       oTxDv;
    logic [4:0] oCount;
    logic       oEmpty;
    logic       oFull;
    logic       oOverflow;
    logic [7:0] oLastByte;

    int         total;
    int         bad;
    int         doubleDv;
    int         peakCount;
    int         frameCnt;
    logic [7:0] txLog [$];

    uart_loopback_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .CR_CODE    (8'h0D),
        .LF_CODE    (8'h0A)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_rx_byte   (rxByte),
        .i_rx_valid  (rxValid),
        .i_pause     (pause),
        .i_crlf_en   (crlfEn),
        .i_clear_ovf (clearOvf),
        .i_tx_active (txActive),
        .i_tx_done   (txDone),
        .o_tx_byte   (oTxByte),
        .o_tx_dv     (oTxDv),
        .o_count     (oCount),
        .o_empty     (oEmpty),
        .o_full      (oFull),
        .o_overflow  (oOverflow),
        .o_last_byte (oLastByte)
    );

    // 25 MHz clock.
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Transmitter model: goes active after a launch strobe, raises done in its
    // last busy cycle, then drops active; logs every launched byte.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            txActive <= 1'b0;
            txDone   <= 1'b0;
            frameCnt <= 0;
        end else begin
            if (txDone) begin
                txDone   <= 1'b0;
                txActive <= 1'b0;
            end
            if (oTxDv) begin
                if (txActive && !txDone) doubleDv <= doubleDv + 1;
                txLog.push_back(oTxByte);
                txActive <= 1'b1;
                frameCnt <= FRAME - 1;
            end else if (txActive && !txDone) begin
                if (frameCnt <= 1) txDone <= 1'b1;
                else frameCnt <= frameCnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (int'(oCount) > peakCount) peakCount = int'(oCount);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxByte  = b;
        rxValid = 1'b1;
        tick(1);
        rxValid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        doubleDv  = 0;
        peakCount = 0;
        rstN      = 1'b0;
        rxByte    = '0;
        rxValid   = 1'b0;
        pause     = 1'b0;
        crlfEn    = 1'b0;
        clearOvf  = 1'b0;

        // Reset state.
        tick(3);
        checkOutput("rst_count", 32'(oCount), 32'd0);
        checkOutput("rst_empty", 32'(oEmpty), 32'd1);
        checkOutput("rst_full", 32'(oFull), 32'd0);
        checkOutput("rst_ovf", 32'(oOverflow), 32'd0);
        checkOutput("rst_last", 32'(oLastByte), 32'd0);
        checkOutput("rst_dv", 32'(oTxDv), 32'd0);
        checkOutput("rst_txbyte", 32'(oTxByte), 32'd0);
        rstN = 1'b1;
        tick(2);

        // Single byte.
        applyStimulus(8'h41);
        checkOutput("single_count1", 32'(oCount), 32'd1);
        checkOutput("single_last", 32'(oLastByte), 32'h41);
        checkOutput("single_dv_early", 32'(oTxDv), 32'd0);
        tick(1);
        checkOutput("single_dv", 32'(oTxDv), 32'd1);
        checkOutput("single_byte", 32'(oTxByte), 32'h41);
        checkOutput("single_count0", 32'(oCount), 32'd0);
        tick(1);
        checkOutput("single_dv_pulse", 32'(oTxDv), 32'd0);
        tick(30);
        checkOutput("single_logsize", 32'(txLog.size()), 32'd1);
        if (txLog.size() >= 1) checkOutput("single_logbyte", 32'(txLog[0]), 32'h41);
        txLog.delete();

        // Burst of five bytes spaced two cycles apart.
        peakCount = 0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i));
            tick(1);
        end
        tick(150);
        checkOutput("burst_logsize", 32'(txLog.size()), 32'd5);
        for (int i = 0; i < 5 && i < txLog.size(); i++)
            checkOutput($sformatf("burst_byte%0d", i), 32'(txLog[i]), 32'(i + 1));
        checkOutput("burst_peak", 32'(peakCount), 32'd4);
        checkOutput("burst_doubledv", 32'(doubleDv), 32'd0);
        txLog.delete();

        // Overflow while paused.
        pause = 1'b1;
        for (int i = 0; i < 17; i++) applyStimulus(8'(8'h10 + i));
        checkOutput("ovf_full", 32'(oFull), 32'd1);
        checkOutput("ovf_count", 32'(oCount), 32'd16);
        checkOutput("ovf_flag", 32'(oOverflow), 32'd1);
        checkOutput("ovf_last", 32'(oLastByte), 32'h1F);
        checkOutput("ovf_paused_nolaunch", 32'(txLog.size()), 32'd0);
        clearOvf = 1'b1;
        tick(1);
        clearOvf = 1'b0;
        checkOutput("ovf_cleared", 32'(oOverflow), 32'd0);
        pause = 1'b0;
        tick(420);
        checkOutput("ovf_logsize", 32'(txLog.size()), 32'd16);
        if (txLog.size() == 16) begin
            checkOutput("ovf_first", 32'(txLog[0]), 32'h10);
            checkOutput("ovf_lastsent", 32'(txLog[15]), 32'h1F);
        end
        checkOutput("ovf_drained", 32'(oEmpty), 32'd1);
        txLog.delete();

        // CR expansion enabled.
        crlfEn = 1'b1;
        applyStimulus(8'h0D);
        applyStimulus(8'h42);
        tick(100);
        checkOutput("crlf_on_size", 32'(txLog.size()), 32'd3);
        if (txLog.size() == 3) begin
            checkOutput("crlf_on_0", 32'(txLog[0]), 32'h0D);
            checkOutput("crlf_on_1", 32'(txLog[1]), 32'h0A);
            checkOutput("crlf_on_2", 32'(txLog[2]), 32'h42);
        end
        txLog.delete();

        // CR expansion disabled.
        crlfEn = 1'b0;
        applyStimulus(8'h0D);
        applyStimulus(8'h42);
        tick(100);
        checkOutput("crlf_off_size", 32'(txLog.size()), 32'd2);
        if (txLog.size() == 2) begin
            checkOutput("crlf_off_0", 32'(txLog[0]), 32'h0D);
            checkOutput("crlf_off_1", 32'(txLog[1]), 32'h42);
        end
        txLog.delete();

        // Full FIFO with push and pop in the same cycle.
        pause = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h60 + i));
        pause = 1'b0;
        tick(2);
        applyStimulus(8'h70);
        checkOutput("fullpp_prefull", 32'(oFull), 32'd1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                if (txDone) seen = 1'b1;
                else tick(1);
            end
            checkOutput("fullpp_done_seen", 32'(seen), 32'd1);
        end
        applyStimulus(8'h77);
        checkOutput("fullpp_ovf", 32'(oOverflow), 32'd0);
        checkOutput("fullpp_count", 32'(oCount), 32'd16);
        checkOutput("fullpp_last", 32'(oLastByte), 32'h77);
        tick(450);
        checkOutput("fullpp_logsize", 32'(txLog.size()), 32'd18);
        if (txLog.size() == 18) begin
            checkOutput("fullpp_byte16", 32'(txLog[16]), 32'h70);
            checkOutput("fullpp_byte17", 32'(txLog[17]), 32'h77);
        end
        txLog.delete();

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'hA1 + i));
        tick(3);
        checkOutput("midrst_pre_count", 32'(oCount), 32'd3);
        checkOutput("midrst_pre_state", 32'(dut.state_q), 32'(S_BUSY));
        rstN = 1'b0;
        #1;
        checkOutput("midrst_count", 32'(oCount), 32'd0);
        checkOutput("midrst_empty", 32'(oEmpty), 32'd1);
        checkOutput("midrst_dv", 32'(oTxDv), 32'd0);
        checkOutput("midrst_state", 32'(dut.state_q), 32'(S_IDLE));
        checkOutput("midrst_lf", 32'(dut.lfPending_q), 32'd0);
        tick(1);
        checkOutput("midrst_edge_count", 32'(oCount), 32'd0);
        checkOutput("midrst_edge_txbyte", 32'(oTxByte), 32'd0);
        rstN = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
